// File: rtl/regfile_2w2r.sv
// Register file with two combinational read ports, one byte-enabled write port (3)
// and one full-word write port (4); port 4 wins same-address collisions, which are flagged.
module regfile_2w2r #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      ra1,
  input  logic [AW-1:0]      ra2,
  output logic [WIDTH-1:0]   rd1,
  output logic [WIDTH-1:0]   rd2,
  input  logic               we3,
  input  logic [AW-1:0]      wa3,
  input  logic [WIDTH-1:0]   wd3,
  input  logic [WIDTH/8-1:0] be3,
  input  logic               we4,
  input  logic [AW-1:0]      wa4,
  input  logic [WIDTH-1:0]   wd4,
  output logic               wcoll
);

  localparam int DEPTH = 1 << AW;
  localparam int NB    = WIDTH / 8;

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("regfile_2w2r: WIDTH must be a positive multiple of 8");
  end
  if (AW < 1 || AW > 8) begin : g_bad_aw
    $error("regfile_2w2r: AW must be in 1..8");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic wr3_en;
  logic wr4_en;
  logic coll;

  // Replace the bytes of old_val selected by be with the matching bytes of new_val.
  function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0] old_val,
                                                  input logic [WIDTH-1:0] new_val,
                                                  input logic [NB-1:0]    be);
    logic [WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic is_zero_addr(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A write to the hardwired zero register is not a write at all, so it can
  // neither change state nor raise the collision flag.
  always_comb begin
    wr3_en = we3 && !is_zero_addr(wa3);
    wr4_en = we4 && !is_zero_addr(wa4);
    coll   = wr3_en && wr4_en && (wa3 == wa4);
  end

  // NOTE: the whole array is reset here because reset is required to clear every
  // register; this forces flops rather than a RAM macro, which is intended.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wcoll <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // letting both ports update different entries in the same edge.
      for (int i = 0; i < DEPTH; i++) begin
        if (wr4_en && wa4 == AW'(i)) begin
          mem[i] <= wd4;
        end else if (wr3_en && wa3 == AW'(i)) begin
          mem[i] <= byte_merge(mem[i], wd3, be3);
        end
      end
      wcoll <= coll;
    end
  end

  // Value a read port returns: stored word, optionally overlaid with this cycle's
  // pending writes (port 4 over port 3 over stored bytes).
  function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0]    ra,
                                                 input logic [WIDTH-1:0] stored,
                                                 input logic             w3,
                                                 input logic             w4);
    logic [WIDTH-1:0] val;
    val = stored;
    if (BYPASS != 0) begin
      if (w4 && ra == wa4) begin
        val = wd4;
      end else if (w3 && ra == wa3) begin
        val = byte_merge(stored, wd3, be3);
      end
    end
    if (is_zero_addr(ra)) val = '0;
    return val;
  endfunction

  // NOTE: every output gets a value on every path through this block, so no latch
  // is inferred.
  always_comb begin
    rd1 = read_word(ra1, mem[ra1], wr3_en, wr4_en);
    rd2 = read_word(ra2, mem[ra2], wr3_en, wr4_en);
  end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench for regfile_2w2r: a vector table run against a registered-read
// instance and a write-through instance, plus a few hand-written multi-cycle sequences.
module tb_regfile_2w2r;

  logic        clk;
  logic        rst;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2, rd1_bp, rd2_bp;
  logic        we3, we4;
  logic [4:0]  wa3, wa4;
  logic [31:0] wd3, wd4;
  logic [3:0]  be3;
  logic        wcoll, wcoll_bp;

  int checks   = 0;
  int failures = 0;

  regfile_2w2r dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .be3(be3),
    .we4(we4), .wa4(wa4), .wd4(wd4), .wcoll(wcoll)
  );

  regfile_2w2r #(.BYPASS(1)) dut_bp (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_bp), .rd2(rd2_bp),
    .we3(we3), .wa3(wa3), .wd3(wd3), .be3(be3),
    .we4(we4), .wa4(wa4), .wd4(wd4), .wcoll(wcoll_bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [3:0]  be3;
    bit          we4;
    logic [4:0]  wa4;
    logic [31:0] wd4;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;   // registered-read instance, before the edge
    logic [31:0] e2;
    bit          ec;
    logic [31:0] b1;   // write-through instance, before the edge
    logic [31:0] b2;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; be3 = '0;
    we4 = 1'b0; wa4 = '0; wd4 = '0;
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; we3 = v.we3; wa3 = v.wa3; wd3 = v.wd3; be3 = v.be3;
    we4 = v.we4; wa4 = v.wa4; wd4 = v.wd4; ra1 = v.ra1; ra2 = v.ra2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_word;

    // chk rst we3 wa3 wd3 be3 we4 wa4 wd4 ra1 ra2 | e1 e2 ec | b1 b2
    vecs.push_back('{0,1, 0,5'd0,32'h0,4'h0,          0,5'd0,32'h0,        5'd0,5'd0, 32'h0,32'h0,0, 32'h0,32'h0});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          0,5'd0,32'h0,        5'd1,5'd0, 32'h0,32'h0,0, 32'h0,32'h0});
    vecs.push_back('{1,0, 1,5'd1,32'h1,4'hF,          0,5'd0,32'h0,        5'd1,5'd0, 32'h0,32'h0,0, 32'h1,32'h0});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          0,5'd0,32'h0,        5'd1,5'd0, 32'h1,32'h0,0, 32'h1,32'h0});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          1,5'd2,32'hAABBCCDD, 5'd2,5'd2, 32'h0,32'h0,0, 32'hAABBCCDD,32'hAABBCCDD});
    vecs.push_back('{1,0, 1,5'd2,32'h11223344,4'h5,   0,5'd0,32'h0,        5'd2,5'd1, 32'hAABBCCDD,32'h1,0, 32'hAA22CC44,32'h1});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          0,5'd0,32'h0,        5'd2,5'd2, 32'hAA22CC44,32'hAA22CC44,0, 32'hAA22CC44,32'hAA22CC44});
    vecs.push_back('{1,0, 1,5'd7,32'h11111111,4'hF,   1,5'd7,32'h22222222, 5'd7,5'd2, 32'h0,32'hAA22CC44,0, 32'h22222222,32'hAA22CC44});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          0,5'd0,32'h0,        5'd7,5'd7, 32'h22222222,32'h22222222,1, 32'h22222222,32'h22222222});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          0,5'd0,32'h0,        5'd7,5'd1, 32'h22222222,32'h1,0, 32'h22222222,32'h1});
    vecs.push_back('{1,0, 1,5'd0,32'hFFFFFFFF,4'hF,   1,5'd0,32'hFFFFFFFF, 5'd0,5'd0, 32'h0,32'h0,0, 32'h0,32'h0});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          0,5'd0,32'h0,        5'd0,5'd7, 32'h0,32'h22222222,0, 32'h0,32'h22222222});
    vecs.push_back('{1,0, 1,5'd5,32'hDEADBEEF,4'h0,   0,5'd0,32'h0,        5'd5,5'd5, 32'h0,32'h0,0, 32'h0,32'h0});
    vecs.push_back('{1,0, 1,5'd6,32'hFFFFFFFF,4'h0,   1,5'd6,32'h0000600D, 5'd5,5'd6, 32'h0,32'h0,0, 32'h0,32'h0000600D});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          0,5'd0,32'h0,        5'd6,5'd3, 32'h0000600D,32'h0,1, 32'h0000600D,32'h0});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          1,5'd3,32'h5A5A5A5A, 5'd6,5'd3, 32'h0000600D,32'h0,0, 32'h0000600D,32'h5A5A5A5A});
    vecs.push_back('{1,0, 1,5'd8,32'h01020304,4'hF,   1,5'd9,32'h0A0B0C0D, 5'd3,5'd8, 32'h5A5A5A5A,32'h0,0, 32'h5A5A5A5A,32'h01020304});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          0,5'd0,32'h0,        5'd8,5'd9, 32'h01020304,32'h0A0B0C0D,0, 32'h01020304,32'h0A0B0C0D});
    vecs.push_back('{1,1, 0,5'd0,32'h0,4'h0,          1,5'd4,32'h12345678, 5'd4,5'd8, 32'h0,32'h01020304,0, 32'h12345678,32'h01020304});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          0,5'd0,32'h0,        5'd4,5'd8, 32'h0,32'h0,0, 32'h0,32'h0});
    vecs.push_back('{1,0, 0,5'd0,32'h0,4'h0,          0,5'd0,32'h0,        5'd9,5'd2, 32'h0,32'h0,0, 32'h0,32'h0});

    idle();
    rst = 1'b1; ra1 = '0; ra2 = '0;
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("v%0d rd1", i), rd1, vecs[i].e1);
        check($sformatf("v%0d rd2", i), rd2, vecs[i].e2);
        check($sformatf("v%0d wcoll", i), {31'b0, wcoll}, {31'b0, vecs[i].ec});
        check($sformatf("v%0d rd1_bp", i), rd1_bp, vecs[i].b1);
        check($sformatf("v%0d rd2_bp", i), rd2_bp, vecs[i].b2);
        check($sformatf("v%0d wcoll_bp", i), {31'b0, wcoll_bp}, {31'b0, vecs[i].ec});
      end
      next_cycle();
    end

    // Back-to-back collisions hold wcoll for two cycles, then it drops.
    idle();
    we3 = 1'b1; wa3 = 5'd10; wd3 = 32'h33333333; be3 = 4'hF;
    we4 = 1'b1; wa4 = 5'd10; wd4 = 32'h44444444;
    next_cycle();
    wd4 = 32'h55555555;
    @(negedge clk);
    check("b2b wcoll 1st", {31'b0, wcoll}, 32'h1);
    next_cycle();
    idle();
    ra1 = 5'd10; ra2 = 5'd10;
    @(negedge clk);
    check("b2b wcoll 2nd", {31'b0, wcoll}, 32'h1);
    check("b2b rd1", rd1, 32'h55555555);
    check("b2b rd2", rd2, 32'h55555555);
    next_cycle();
    @(negedge clk);
    check("b2b wcoll drop", {31'b0, wcoll}, 32'h0);

    // A collision presented with reset is lost and leaves wcoll clear.
    next_cycle();
    rst = 1'b1;
    we3 = 1'b1; wa3 = 5'd11; wd3 = 32'h66666666; be3 = 4'hF;
    we4 = 1'b1; wa4 = 5'd11; wd4 = 32'h77777777;
    next_cycle();
    idle();
    ra1 = 5'd11; ra2 = 5'd10;
    @(negedge clk);
    check("rst coll wcoll", {31'b0, wcoll}, 32'h0);
    check("rst coll rd1", rd1, 32'h0);
    check("rst coll rd2", rd2, 32'h0);

    // Walk a single byte enable across the word, accumulating bytes.
    exp_word = 32'h0;
    ra1 = 5'd12; ra2 = 5'd12;
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      we3 = 1'b1; wa3 = 5'd12; wd3 = 32'hC3C3C3C3; be3 = 4'(1 << b);
      next_cycle();
      idle();
      exp_word[8*b +: 8] = 8'hC3;
      @(negedge clk);
      check($sformatf("be walk %0d rd1", b), rd1, exp_word);
      check($sformatf("be walk %0d rd2_bp", b), rd2_bp, exp_word);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
